// File: rtl/prbs_pkg.sv
// Shared encodings for the PRBS bit checker: pattern select codes, tap positions
// and checker state.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEL_PRBS7     = 2'b00,
        SEL_PRBS15    = 2'b01,
        SEL_PRBS31    = 2'b10,
        SEL_PRBS7_ALT = 2'b11
    } prbs_sel_e;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int REF_W  = 31;
    localparam int FILL_W = 5;

    localparam int TAP7_A  = 7;
    localparam int TAP7_B  = 6;
    localparam int TAP15_A = 15;
    localparam int TAP15_B = 14;
    localparam int TAP31_A = 31;
    localparam int TAP31_B = 28;

    // Pattern order N doubles as the number of bits needed to seed the reference.
    function automatic logic [FILL_W-1:0] prbs_len(input prbs_sel_e sel);
        case (sel)
            SEL_PRBS15: return FILL_W'(TAP15_A);
            SEL_PRBS31: return FILL_W'(TAP31_A);
            default:    return FILL_W'(TAP7_A);
        endcase
    endfunction

endpackage

// File: rtl/prbs_ref_lfsr.sv
// Reference register for the PRBS checker: predicts the next bit from the selected
// taps and either seeds from received data or free-runs on its own prediction.
module prbs_ref_lfsr
    import prbs_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      shift_en,
    input  logic      seed_mode,
    input  logic      bit_in,
    input  prbs_sel_e sel,
    output logic      pred
);

    logic [REF_W-1:0] ref_q;
    logic [REF_W-1:0] ref_d;
    logic             new_bit;

    always_comb begin
        case (sel)
            SEL_PRBS15: pred = ref_q[TAP15_A-1] ^ ref_q[TAP15_B-1];
            SEL_PRBS31: pred = ref_q[TAP31_A-1] ^ ref_q[TAP31_B-1];
            default:    pred = ref_q[TAP7_A-1]  ^ ref_q[TAP7_B-1];
        endcase
    end

    assign new_bit = seed_mode ? bit_in : pred;
    assign ref_d   = shift_en ? {ref_q[REF_W-2:0], new_bit} : ref_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_d;
        end
    end

endmodule

// File: rtl/prbs_bit_checker.sv
// Self-synchronising PRBS checker: acquires lock on the received stream, then
// counts checked bits and bit errors for BER, dropping lock on an error burst.
module prbs_bit_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THRESH = 64,
    parameter int UNLOCK_WIN  = 256,
    parameter int UNLOCK_ERRS = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bit_in,
    input  logic             bit_in_valid,
    input  logic             enable,
    input  logic [1:0]       prbs_sel,
    input  logic             cnt_clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W  = $clog2(UNLOCK_WIN + 1);
    localparam int WERR_W = $clog2(UNLOCK_ERRS + 1);

    state_e              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [GOOD_W-1:0]   good_q, good_d, good_inc;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d, win_cnt_inc;
    logic [WERR_W-1:0]   win_err_q, win_err_d, win_err_inc;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                lock_lost_q, lock_lost_d;
    logic                err_pulse_q, err_pulse_d;

    logic                pred;
    logic                mis;
    logic                shift_en;
    logic                seed_mode;
    logic                force_search;
    logic [FILL_W-1:0]   fill_target;

    prbs_ref_lfsr u_ref (
        .clk       (clk),
        .rstn      (rstn),
        .shift_en  (shift_en),
        .seed_mode (seed_mode),
        .bit_in    (bit_in),
        .sel       (prbs_sel_e'(sel_q)),
        .pred      (pred)
    );

    assign mis          = bit_in ^ pred;
    assign seed_mode    = (state_q == ST_SEARCH);
    assign force_search = !enable || (prbs_sel != sel_q);
    assign fill_target  = prbs_len(prbs_sel_e'(sel_q));
    assign good_inc     = good_q + 1'b1;
    assign win_cnt_inc  = win_cnt_q + 1'b1;
    assign win_err_inc  = win_err_q + WERR_W'(mis);

    always_comb begin
        state_d     = state_q;
        sel_d       = prbs_sel;
        fill_d      = fill_q;
        good_d      = good_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        lock_lost_d = lock_lost_q;
        err_pulse_d = 1'b0;
        shift_en    = 1'b0;

        if (force_search) begin
            state_d   = ST_SEARCH;
            fill_d    = '0;
            good_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (bit_in_valid) begin
            shift_en = 1'b1;
            case (state_q)
                ST_SEARCH: begin
                    if (fill_q != fill_target) begin
                        fill_d = fill_q + 1'b1;
                    end else if (mis) begin
                        good_d = '0;
                    end else if (good_inc == GOOD_W'(LOCK_THRESH)) begin
                        state_d   = ST_LOCKED;
                        good_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                ST_LOCKED: begin
                    if (bit_cnt_q != {CNT_W{1'b1}}) bit_cnt_d = bit_cnt_q + 1'b1;
                    if (mis) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
                    end
                    // An error burst that fills the budget wins over a coincident window wrap.
                    if (win_err_inc == WERR_W'(UNLOCK_ERRS)) begin
                        state_d     = ST_SEARCH;
                        lock_lost_d = 1'b1;
                        fill_d      = '0;
                        good_d      = '0;
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else if (win_cnt_inc == WIN_W'(UNLOCK_WIN)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        if (cnt_clear) begin
            bit_cnt_d   = '0;
            err_cnt_d   = '0;
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_SEARCH;
            sel_q       <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            lock_lost_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            lock_lost_q <= lock_lost_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_bit_checker.sv
// Scoreboard bench for prbs_bit_checker: a reference PRBS generator drives the
// checker and per-bit expectations are queued at drive time, then compared.
module tb_prbs_bit_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bit_in;
    logic        bit_in_valid;
    logic        enable;
    logic [1:0]  prbs_sel;
    logic        cnt_clear;

    logic        locked, err_pulse, lock_lost;
    logic [31:0] bit_count, err_count;
    logic        locked4, err_pulse4, lock_lost4;
    logic [3:0]  bit_count4, err_count4;

    typedef struct packed {
        logic lk;
        logic pl;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    logic [30:0] gen_q;
    int          gen_a, gen_b;

    always #5 clk = ~clk;

    prbs_bit_checker dut (
        .clk          (clk),
        .rstn         (rstn),
        .bit_in       (bit_in),
        .bit_in_valid (bit_in_valid),
        .enable       (enable),
        .prbs_sel     (prbs_sel),
        .cnt_clear    (cnt_clear),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .lock_lost    (lock_lost),
        .bit_count    (bit_count),
        .err_count    (err_count)
    );

    prbs_bit_checker #(.CNT_W(4)) dut_w4 (
        .clk          (clk),
        .rstn         (rstn),
        .bit_in       (bit_in),
        .bit_in_valid (bit_in_valid),
        .enable       (enable),
        .prbs_sel     (prbs_sel),
        .cnt_clear    (cnt_clear),
        .locked       (locked4),
        .err_pulse    (err_pulse4),
        .lock_lost    (lock_lost4),
        .bit_count    (bit_count4),
        .err_count    (err_count4)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle; expectations for valid bits go on the scoreboard.
    task automatic step(input logic v, input logic b, input logic exp_lk, input logic exp_pl);
        bit_in_valid = v;
        bit_in       = b;
        if (v && rstn) sb_q.push_back('{lk: exp_lk, pl: exp_pl});
        @(posedge clk);
        #1;
        bit_in_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_pattern(input logic [1:0] sel);
        prbs_sel = sel;
        case (sel)
            2'b01:   begin gen_a = 15; gen_b = 14; end
            2'b10:   begin gen_a = 31; gen_b = 28; end
            default: begin gen_a = 7;  gen_b = 6;  end
        endcase
        gen_q = 31'h2A5F_31C7;
        idle();
    endtask

    task automatic gen_next(output logic b);
        b     = gen_q[gen_a-1] ^ gen_q[gen_b-1];
        gen_q = {gen_q[29:0], b};
    endtask

    // lock_at: <0 never locked, 0 already locked, >0 locked from that bit on.
    task automatic run_bits(input int n, input int lock_at, input int gap, input int err_every);
        logic b, flip, lk;
        for (int k = 1; k <= n; k++) begin
            gen_next(b);
            flip = (err_every > 0) && (k % err_every == 0);
            lk   = (lock_at == 0) ? 1'b1 : ((lock_at > 0) && (k >= lock_at));
            step(1'b1, b ^ flip, lk, flip);
            repeat (gap) idle();
        end
    endtask

    initial begin : monitor
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = bit_in_valid && rstn;
            #1;
            if (v) begin
                check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("locked_per_bit", 64'(locked), 64'(e.lk));
                    check("err_pulse_per_bit", 64'(err_pulse), 64'(e.pl));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin : stim
        logic b;
        rstn = 1'b0; bit_in = 1'b0; bit_in_valid = 1'b0;
        enable = 1'b1; prbs_sel = 2'b00; cnt_clear = 1'b0;
        gen_a = 7; gen_b = 6; gen_q = 31'h2A5F_31C7;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked",    64'(locked),    64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_lock_lost", 64'(lock_lost), 64'd0);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        rstn = 1'b1;
        idle();

        // PRBS7 acquisition: lock after exactly 7 + 64 bits, then clean run
        run_bits(71, 71, 0, 0);
        run_bits(1000, 0, 0, 0);
        check("p7_err_count", 64'(err_count), 64'd0);
        check("p7_bit_count", 64'(bit_count), 64'd1000);

        // pattern change while locked drops lock without lock_lost, counters held
        set_pattern(2'b10);
        check("sel_chg_locked",    64'(locked),    64'd0);
        check("sel_chg_lock_lost", 64'(lock_lost), 64'd0);
        check("sel_chg_bit_count", 64'(bit_count), 64'd1000);
        check("sel_chg_err_count", 64'(err_count), 64'd0);

        // PRBS31 lock, then 16 inverted bits force loss of lock
        run_bits(95, 95, 0, 0);
        run_bits(20, 0, 0, 0);
        for (int j = 1; j <= 16; j++) begin
            gen_next(b);
            step(1'b1, ~b, (j < 16), 1'b1);
            if (j == 15) check("lock_lost_before_16th", 64'(lock_lost), 64'd0);
        end
        check("lol_locked",    64'(locked),    64'd0);
        check("lol_lock_lost", 64'(lock_lost), 64'd1);
        check("lol_err_count", 64'(err_count), 64'd16);
        check("lol_bit_count", 64'(bit_count), 64'd1036);
        run_bits(95, 95, 0, 0);
        check("relock_lock_lost_sticky", 64'(lock_lost), 64'd1);

        // clear, then PRBS15 with three isolated errors
        cnt_clear = 1'b1; idle(); cnt_clear = 1'b0;
        check("clr_bit_count", 64'(bit_count), 64'd0);
        check("clr_lock_lost", 64'(lock_lost), 64'd0);
        set_pattern(2'b01);
        run_bits(79, 79, 0, 0);
        run_bits(100, 0, 0, 30);
        check("p15_err_count", 64'(err_count), 64'd3);
        check("p15_bit_count", 64'(bit_count), 64'd100);
        check("p15_locked",    64'(locked),    64'd1);

        // gapped valid: one bit every third cycle
        cnt_clear = 1'b1; idle(); cnt_clear = 1'b0;
        set_pattern(2'b00);
        run_bits(71, 71, 2, 0);
        run_bits(50, 0, 2, 0);
        check("gap_bit_count", 64'(bit_count), 64'd50);
        check("gap_err_count", 64'(err_count), 64'd0);

        // saturation: 20 spaced errors over 600 bits
        cnt_clear = 1'b1; idle(); cnt_clear = 1'b0;
        run_bits(600, 0, 0, 30);
        check("sat_err_count32", 64'(err_count),  64'd20);
        check("sat_bit_count32", 64'(bit_count),  64'd600);
        check("sat_err_count4",  64'(err_count4), 64'd15);
        check("sat_bit_count4",  64'(bit_count4), 64'd15);
        check("sat_locked4",     64'(locked4),    64'd1);

        // clear coincident with an errored bit: clear wins
        cnt_clear = 1'b1;
        gen_next(b);
        step(1'b1, ~b, 1'b1, 1'b1);
        cnt_clear = 1'b0;
        check("clr_err_err_count",  64'(err_count),  64'd0);
        check("clr_err_bit_count",  64'(bit_count),  64'd0);
        check("clr_err_err_count4", 64'(err_count4), 64'd0);

        // enable low forces SEARCH and ignores input
        enable = 1'b0;
        idle();
        check("dis_locked",    64'(locked),    64'd0);
        check("dis_lock_lost", 64'(lock_lost), 64'd0);
        for (int j = 0; j < 5; j++) begin
            gen_next(b);
            step(1'b1, ~b, 1'b0, 1'b0);
        end
        check("dis_bit_count", 64'(bit_count), 64'd0);
        check("dis_err_count", 64'(err_count), 64'd0);
        enable = 1'b1;
        run_bits(71, 71, 0, 0);
        run_bits(10, 0, 0, 0);
        check("pre_rst_bit_count", 64'(bit_count), 64'd10);

        // mid-stream reset clears immediately, reacquires from SEARCH
        rstn = 1'b0;
        #1;
        check("mid_rst_locked",    64'(locked),    64'd0);
        check("mid_rst_bit_count", 64'(bit_count), 64'd0);
        idle();
        rstn = 1'b1;
        idle();
        run_bits(71, 71, 0, 0);
        check("post_rst_bit_count", 64'(bit_count), 64'd0);

        idle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_bit_checker.md
# prbs_bit_checker

Serial PRBS checker on the receive side of the link model. It consumes the recovered bit stream from the PAM4 Gray decoder (`data_out`/`data_out_valid`) and self-synchronises to a selectable PRBS pattern. Once locked, it counts checked bits and bit errors so that the host can compute BER. It is the final stage of the RX datapath.

## Interface
- `LOCK_THRESH`, default 64: consecutive correct predictions required to declare lock.
- `UNLOCK_WIN`, default 256: length of the loss-of-lock observation window, in valid bits.
- `UNLOCK_ERRS`, default 16: errors within one window that force loss of lock.
- `CNT_W`, default 32: width of the bit counter and the error counter.
- `clk`, in, 1: single clock for all logic.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `bit_in`, in, 1: received bit (the Gray decoder's `data_out`).
- `bit_in_valid`, in, 1: `bit_in` is valid this cycle. No backpressure.
- `enable`, in, 1: checker enable. When low, the block is forced to SEARCH and input is ignored.
- `prbs_sel`, in, 2: pattern select.
  - 00: PRBS7, x^7+x^6+1.
  - 01: PRBS15, x^15+x^14+1.
  - 10: PRBS31, x^31+x^28+1.
  - 11: treated as PRBS7.
- `cnt_clear`, in, 1: synchronous clear of `err_count`, `bit_count` and `lock_lost`.
- `locked`, out, 1: high while in LOCKED.
- `err_pulse`, out, 1: one-cycle pulse for each errored bit while locked.
- `lock_lost`, out, 1: sticky flag, set on a LOCKED→SEARCH transition.
- `bit_count`, out, CNT_W: valid bits checked while locked. Saturates.
- `err_count`, out, CNT_W: errored bits while locked. Saturates.

## Operation
- **Reference register** `ref[30:0]`, where `ref[0]` is the newest bit.
  - Prediction `pred = ref[a-1] ^ ref[b-1]`, with (a,b) = (7,6), (15,14) or (31,28) per `prbs_sel`.
  - `mis = bit_in ^ pred`.
  - The register shifts only on `bit_in_valid`.
- **SEARCH** (reset state):
  - Each valid bit is shifted into `ref`, so the register self-seeds from received data.
  - The fill counter counts to N (7/15/31). No comparisons are made until fill reaches N.
  - After fill, a correct prediction increments the good counter; a mismatch sets it to 0 and the received bit is still shifted in.
  - The valid bit that brings the good counter to `LOCK_THRESH` moves the block to LOCKED.
  - Counters do not change in SEARCH.
- **LOCKED**:
  - `ref` shifts in `pred`, not `bit_in`, so the reference is free-running and single errors do not propagate.
  - Each valid bit increments `bit_count`. A mismatch also increments `err_count` and asserts `err_pulse`.
  - The window counter counts valid bits. The window error counter counts mismatches.
  - If window errors reach `UNLOCK_ERRS` before the window counter reaches `UNLOCK_WIN`, the block goes to SEARCH and sets `lock_lost`. The fill and good counters are cleared.
  - At a window boundary both window counters reset to 0.
- **Forced SEARCH**: `enable` low, or `prbs_sel` differing from its registered copy, forces SEARCH with fill, good and window counters cleared.
  - `lock_lost` is not set by this path.
  - `bit_count` and `err_count` are held.
- **Saturation**: `bit_count` and `err_count` stick at 2^CNT_W−1. The error counter keeps saturating independently of the bit counter.
- **`cnt_clear`**: takes priority over an increment in the same cycle. That bit is not counted.

## Timing
- All outputs are registered. Reset value of every output, counter and state is 0, and the state is SEARCH.
- `err_pulse` and the counter updates appear 1 cycle after the `bit_in_valid` cycle of the bit concerned.
- `locked` rises 1 cycle after the `LOCK_THRESH`-th consecutive good bit.
  - Minimum acquisition from reset is N + `LOCK_THRESH` valid bits.
- `locked` falls 1 cycle after the bit that reaches `UNLOCK_ERRS`. `lock_lost` rises in the same cycle.
- A `prbs_sel` change drops `locked` on the next cycle.
- Input gaps (`bit_in_valid` low) stall all state. There is no timeout.
- `rstn` asserted mid-stream clears everything immediately. Operation resumes from SEARCH on the first valid bit after deassertion.

## Structure
- Package `prbs_pkg` holds:
  - the `prbs_sel` encodings;
  - tap constants per pattern;
  - the state encoding (SEARCH, LOCKED).
- Sub-module `prbs_ref_lfsr` contains the 31-bit reference register, the tap mux and the seed-or-free-run shift. The top level holds the FSM and the counters.

## Test plan
- **Lock, PRBS7**: send a clean PRBS7 stream with valid every cycle, `LOCK_THRESH`=64 → `locked` rises after exactly 71 valid bits, and `err_count`=0 after 1000 further bits.
- **Error injection, PRBS15**: lock, then flip 3 isolated bits spaced more than 20 apart → exactly 3 `err_pulse`, `err_count`=3, `locked` stays high.
- **Loss of lock**: lock, then send 16 consecutive inverted bits → `locked` falls and `lock_lost`=1 one cycle after the 16th. Clean data then relocks after 31+64 bits (PRBS31) or 7+64 bits (PRBS7).
- **Gapped valid through Gray decoder**: drive the decoder at one symbol every 3 cycles → lock is achieved and `bit_count` equals the number of valid bits after lock.
- **`prbs_sel` change while locked**: change from PRBS7 to PRBS31 → `locked`=0 next cycle, `lock_lost`=0, counters held.
- **Clear and saturation**: with `CNT_W`=4, 20 errors → `err_count`=15. Assert `cnt_clear` together with an errored bit → `err_count`=0 next cycle.
